// File: rtl/pixel_burst_writer.sv
// pixel_burst_writer: drains RGB565 pixels from the camera FIFO and writes them
// to SDRAM as fixed-length bursts at linearly increasing frame-buffer addresses.
module pixel_burst_writer #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              frame_start,
  input  logic [CNT_W-1:0]  data_count_r,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              rd_en,
  output logic              sd_wr_req,
  input  logic              sd_wr_ack,
  output logic [ADDR_W-1:0] sd_wr_addr,
  output logic [DATA_W-1:0] sd_wr_data,
  output logic              sd_wr_valid,
  input  logic              sd_wr_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned OFF_W = $clog2(FRAME_WORDS + 1);
  localparam int unsigned RC_W  = $clog2(BURST_LEN + 1);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN);
  localparam logic [OFF_W-1:0]  OFF_STEP  = OFF_W'(BURST_LEN);
  localparam logic [OFF_W-1:0]  OFF_END   = OFF_W'(FRAME_WORDS);
  localparam logic [RC_W-1:0]   RC_FULL   = RC_W'(BURST_LEN);
  localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_THR   = CNT_W'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr;
  logic [OFF_W-1:0]    offset;
  logic [OFF_W-1:0]    next_off;
  logic                wrap;
  logic                fs_pend;
  logic                fs_hit;
  logic [RC_W-1:0]     rd_cnt;
  logic [RC_W-1:0]     wr_cnt;
  logic                inflight;
  logic [DATA_W-1:0]   buf_q [0:1];
  logic [1:0]          buf_cnt;
  logic                head;
  logic                tail;
  logic                pop;
  logic [2:0]          occ;

  assign next_off = offset + OFF_STEP;
  assign wrap     = (next_off == OFF_END);
  assign fs_hit   = fs_pend | frame_start;
  assign tail     = head ^ buf_cnt[0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state decode and all outputs
  always_comb begin
    state_n     = state;
    rd_en       = 1'b0;
    sd_wr_req   = 1'b0;
    sd_wr_addr  = '0;
    sd_wr_valid = 1'b0;
    sd_wr_data  = '0;
    busy        = (state != IDLE);
    frame_done  = 1'b0;
    pop         = 1'b0;
    occ         = '0;
    case (state)
      IDLE: begin
        if (enable && (data_count_r >= CNT_THR)) state_n = REQ;
      end
      REQ: begin
        sd_wr_req  = 1'b1;
        sd_wr_addr = addr;
        if (sd_wr_ack) state_n = XFER;
      end
      XFER: begin
        sd_wr_valid = (buf_cnt != 2'd0);
        sd_wr_data  = sd_wr_valid ? buf_q[head] : '0;
        pop         = sd_wr_valid && sd_wr_ready;
        // Occupancy credits this cycle's pop so rd_en can stay high back-to-back
        // while the sink accepts every cycle; the buffer still never exceeds 2.
        occ         = {1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, pop};
        rd_en       = (rd_cnt < RC_FULL) && (occ < 3'd2);
        if (pop && (wr_cnt == RC_LAST)) state_n = DONE;
      end
      DONE: begin
        frame_done = !fs_hit && wrap;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Address/offset tracking, burst counters and skid buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= BASE;
      offset   <= '0;
      fs_pend  <= 1'b0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      inflight <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      buf_cnt  <= '0;
      head     <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (inflight) buf_q[tail] <= fifo_dout;
      buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
      if (pop) head <= ~head;
      if (rd_en) rd_cnt <= rd_cnt + 1'b1;
      if (pop)   wr_cnt <= wr_cnt + 1'b1;
      case (state)
        IDLE: begin
          rd_cnt <= '0;
          wr_cnt <= '0;
          if (frame_start) begin
            addr   <= BASE;
            offset <= '0;
          end
        end
        REQ, XFER: begin
          if (frame_start) fs_pend <= 1'b1;
        end
        DONE: begin
          fs_pend <= 1'b0;
          if (fs_hit || wrap) begin
            addr   <= BASE;
            offset <= '0;
          end else begin
            addr   <= addr + ADDR_STEP;
            offset <= next_off;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_burst_writer.sv
// Scoreboard bench for pixel_burst_writer: a FIFO model feeds numbered pixels,
// a monitor pops expected addresses/words as the DUT presents them.
module tb_pixel_burst_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  data_count_r = '0;
  logic [15:0] fifo_dout = '0;
  logic        rd_en;
  logic        sd_wr_req;
  logic        sd_wr_ack = 1'b0;
  logic [23:0] sd_wr_addr;
  logic [15:0] sd_wr_data;
  logic        sd_wr_valid;
  logic        sd_wr_ready = 1'b0;
  logic        busy;
  logic        frame_done;

  pixel_burst_writer #(
    .DATA_W(16), .CNT_W(10), .ADDR_W(24), .BURST_LEN(16),
    .FRAME_WORDS(64), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
    .data_count_r(data_count_r), .fifo_dout(fifo_dout), .rd_en(rd_en),
    .sd_wr_req(sd_wr_req), .sd_wr_ack(sd_wr_ack), .sd_wr_addr(sd_wr_addr),
    .sd_wr_data(sd_wr_data), .sd_wr_valid(sd_wr_valid),
    .sd_wr_ready(sd_wr_ready), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [23:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  int unsigned fifo_idx = 0;
  int unsigned rd_total = 0;
  int unsigned run = 0;
  int unsigned maxrun = 0;
  int unsigned ready_mode = 1;
  int unsigned cyc = 0;
  int unsigned acc_n = 0;
  int unsigned acc_first = 0;
  int unsigned acc_last = 0;
  int unsigned fd_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FIFO model: data appears one cycle after rd_en, numbered 16'hC000+index
  initial begin
    logic rd;
    forever begin
      @(negedge clk);
      rd = rd_en;
      @(posedge clk);
      #1;
      if (rd) begin
        fifo_dout = 16'hC000 + 16'(fifo_idx);
        fifo_idx++;
        rd_total++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
  end

  // SDRAM ready pattern: 1=always, 2=toggle, 3=random stalls
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: sd_wr_ready = 1'b1;
        2: sd_wr_ready = ~sd_wr_ready;
        default: sd_wr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares grants, accepted words and frame_done pulses
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (sd_wr_req && sd_wr_ack) begin
          if (exp_addr_q.size() == 0) chk("unexpected_req", 64'(sd_wr_addr), 64'hDEAD);
          else chk("burst_addr", 64'(sd_wr_addr), 64'(exp_addr_q.pop_front()));
        end
        if (sd_wr_valid && sd_wr_ready) begin
          if (exp_data_q.size() == 0) chk("unexpected_word", 64'(sd_wr_data), 64'hDEAD);
          else chk("burst_word", 64'(sd_wr_data), 64'(exp_data_q.pop_front()));
          if (acc_n == 0) acc_first = cyc;
          acc_last = cyc;
          acc_n++;
        end
        if (frame_done) fd_seen++;
      end
    end
  end

  task automatic run_burst(input logic [23:0] a, input int unsigned mode,
                           input bit fs_mid, input bit rst_mid);
    bit got;
    int unsigned rd0;
    ready_mode = mode;
    exp_addr_q.push_back(a);
    rd0 = rd_total;
    acc_n = 0;
    maxrun = 0;
    data_count_r = 10'd16;
    enable = 1'b1;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sd_wr_req) begin got = 1; break; end
    end
    chk("req_seen", 64'(got), 64'd1);
    if (!got) return;
    tick();
    enable = 1'b0;
    data_count_r = '0;
    sd_wr_ack = 1'b1;
    for (int k = 0; k < 16; k++) exp_data_q.push_back(16'hC000 + 16'(fifo_idx + k));
    tick();
    sd_wr_ack = 1'b0;
    if (fs_mid) begin
      tick(); tick(); tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
    if (rst_mid) begin
      got = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (acc_n >= 5) begin got = 1; break; end
      end
      chk("rst_mid_progress", 64'(got), 64'd1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs_zero",
          {21'd0, rd_en, sd_wr_req, sd_wr_valid, busy, frame_done, sd_wr_data, sd_wr_addr}, 64'd0);
      exp_data_q.delete();
      tick(); tick();
      rst_n = 1'b1;
      return;
    end
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin got = 1; break; end
    end
    chk("burst_finished", 64'(got), 64'd1);
    chk("rd_en_count", 64'(rd_total - rd0), 64'd16);
    chk("accepted_count", 64'(acc_n), 64'd16);
    if (mode == 1) begin
      chk("rd_en_back_to_back", 64'(maxrun), 64'd16);
      chk("one_word_per_cycle", 64'(acc_last - acc_first), 64'd15);
    end
  endtask

  initial begin
    bit early;
    tick(); tick();
    @(negedge clk);
    chk("reset_outputs",
        {21'd0, rd_en, sd_wr_req, sd_wr_valid, busy, frame_done, sd_wr_data, sd_wr_addr}, 64'd0);
    tick();
    rst_n = 1'b1;

    // Fill level one short of a burst: no request
    data_count_r = 10'd15;
    enable = 1'b1;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (sd_wr_req || busy) early = 1;
    end
    chk("no_req_at_15", 64'(early), 64'd0);

    run_burst(24'd0, 1, 0, 0);
    run_burst(24'd16, 2, 0, 0);
    run_burst(24'd32, 3, 0, 0);
    chk("no_frame_done_mid_frame", 64'(fd_seen), 64'd0);
    run_burst(24'd48, 3, 0, 0);
    chk("frame_done_once", 64'(fd_seen), 64'd1);
    run_burst(24'd0, 1, 0, 0);
    run_burst(24'd16, 2, 0, 0);
    run_burst(24'd32, 3, 1, 0);
    chk("frame_start_no_frame_done", 64'(fd_seen), 64'd1);
    run_burst(24'd0, 1, 0, 0);
    run_burst(24'd16, 1, 0, 1);
    run_burst(24'd0, 3, 0, 0);

    // frame_start while idle at offset 16 restarts at base
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    run_burst(24'd0, 2, 0, 0);
    chk("frame_done_total", 64'(fd_seen), 64'd1);

    tick(); tick();
    chk("addr_queue_empty", 64'(exp_addr_q.size()), 64'd0);
    chk("data_queue_empty", 64'(exp_data_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
